cve2_ex_ctrl: RTL and testbench



---
 rtl/cve2_ex_ctrl.sv | 162 ++++++++++++++++
 tb/tb_cve2_ex_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cve2_ex_ctrl.sv
// Issue-side sequencer for the execution block: accepts one ALU/MULT/DIV op at a time,
// drives the EX strobes, owns the intermediate-value registers and hands results to writeback.

package cve2_pkg;
  typedef enum integer {
    RV32MNone        = 0,
    RV32MSlow        = 1,
    RV32MFast        = 2,
    RV32MSingleCycle = 3
  } rv32m_e;
endpackage

module cve2_ex_ctrl #(
  parameter cve2_pkg::rv32m_e RV32M     = cve2_pkg::RV32MFast,
  parameter int unsigned      ExTimeout = 40
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             issue_valid_i,
  output logic             issue_ready_o,
  input  logic [1:0]       issue_kind_i,
  input  logic             kill_i,
  output logic             alu_instr_first_cycle_o,
  output logic             mult_en_o,
  output logic             div_en_o,
  output logic             mult_sel_o,
  output logic             div_sel_o,
  input  logic [1:0]       imd_val_we_i,
  input  logic [1:0][33:0] imd_val_d_i,
  output logic [1:0][33:0] imd_val_q_o,
  input  logic             ex_valid_i,
  input  logic [31:0]      result_ex_i,
  output logic             wb_valid_o,
  input  logic             wb_ready_i,
  output logic [31:0]      wb_result_o,
  output logic             busy_o,
  output logic             timeout_o
);

  localparam int unsigned     CntW      = $clog2(ExTimeout + 1);
  localparam logic [CntW-1:0] CntLast   = CntW'(ExTimeout - 1);
  localparam logic            MultDivEn = (RV32M != cve2_pkg::RV32MNone);
  localparam logic [1:0]      KindMult  = 2'b01;
  localparam logic [1:0]      KindDiv   = 2'b10;

  typedef enum logic [1:0] {
    Idle = 2'b00,
    Exec = 2'b01,
    Hold = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       kind_q, kind_d;
  logic             first_q, first_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [31:0]      wb_result_q, wb_result_d;
  logic [1:0][33:0] imd_q, imd_d;

  logic accept;
  logic in_exec;
  logic kill_active;
  logic ex_done;
  logic wd_fire;

  // Acceptance: IDLE takes a new op unless killed; HOLD only when writeback drains this cycle.
  always_comb begin
    issue_ready_o = 1'b0;
    unique case (state_q)
      Idle:    issue_ready_o = rst_ni & ~kill_i;
      Hold:    issue_ready_o = rst_ni & wb_ready_i & ~kill_i;
      default: issue_ready_o = 1'b0;
    endcase
  end

  assign accept      = issue_valid_i & issue_ready_o;
  assign in_exec     = (state_q == Exec);
  assign kill_active = kill_i & (state_q != Idle);
  assign ex_done     = in_exec & ex_valid_i & ~kill_i;
  assign wd_fire     = in_exec & ~kill_i & ~ex_valid_i & (cnt_q == CntLast);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= Idle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      Idle: begin
        if (accept) state_d = Exec;
      end
      Exec: begin
        if (kill_i)                  state_d = Idle;
        else if (ex_valid_i)         state_d = Hold;
        else if (cnt_q == CntLast)   state_d = Idle;
      end
      Hold: begin
        if (kill_i)          state_d = Idle;
        else if (wb_ready_i) state_d = accept ? Exec : Idle;
      end
      default: state_d = Idle;
    endcase
  end

  always_comb begin
    alu_instr_first_cycle_o = in_exec & first_q;
    mult_sel_o              = MultDivEn & in_exec & (kind_q == KindMult);
    div_sel_o               = MultDivEn & in_exec & (kind_q == KindDiv);
    mult_en_o               = MultDivEn & in_exec & (kind_q == KindMult);
    div_en_o                = MultDivEn & in_exec & (kind_q == KindDiv);
    wb_valid_o              = (state_q == Hold);
    timeout_o               = wd_fire & rst_ni;
  end

  // Counter saturates at its terminal value; EXEC always leaves on that cycle anyway.
  always_comb begin
    kind_d      = kind_q;
    first_d     = accept;
    cnt_d       = cnt_q;
    wb_result_d = wb_result_q;
    imd_d       = imd_q;
    if (accept) begin
      kind_d = issue_kind_i;
      cnt_d  = '0;
    end else if (in_exec && !ex_valid_i && (cnt_q != CntLast)) begin
      cnt_d = cnt_q + CntW'(1);
    end
    if (ex_done) wb_result_d = result_ex_i;
    if (kill_active) begin
      imd_d       = '0;
      wb_result_d = '0;
    end else if (in_exec) begin
      for (int k = 0; k < 2; k++) begin
        if (imd_val_we_i[k]) imd_d[k] = imd_val_d_i[k];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      kind_q      <= 2'b00;
      first_q     <= 1'b0;
      cnt_q       <= '0;
      wb_result_q <= '0;
      imd_q       <= '0;
    end else begin
      kind_q      <= kind_d;
      first_q     <= first_d;
      cnt_q       <= cnt_d;
      wb_result_q <= wb_result_d;
      imd_q       <= imd_d;
    end
  end

  assign busy_o      = (state_q != Idle);
  assign wb_result_o = wb_result_q;
  assign imd_val_q_o = imd_q;

endmodule

// File: tb/tb_cve2_ex_ctrl.sv
// Self-checking bench for cve2_ex_ctrl: directed vector table, hand-written corner sequences,
// and a randomized phase checked against a cycle-level behavioural model.

module tb_cve2_ex_ctrl;

  localparam int ExTimeout = 40;

  localparam logic [8:0] fRdy    = 9'h100;
  localparam logic [8:0] fFirst  = 9'h080;
  localparam logic [8:0] fMulEn  = 9'h040;
  localparam logic [8:0] fDivEn  = 9'h020;
  localparam logic [8:0] fMulSel = 9'h010;
  localparam logic [8:0] fDivSel = 9'h008;
  localparam logic [8:0] fValid  = 9'h004;
  localparam logic [8:0] fBusy   = 9'h002;
  localparam logic [8:0] fTout   = 9'h001;
  localparam logic [8:0] fMul    = fMulEn | fMulSel;
  localparam logic [8:0] fDiv    = fDivEn | fDivSel;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             issue_valid_i;
  logic             issue_ready_o;
  logic [1:0]       issue_kind_i;
  logic             kill_i;
  logic             alu_instr_first_cycle_o;
  logic             mult_en_o, div_en_o, mult_sel_o, div_sel_o;
  logic [1:0]       imd_val_we_i;
  logic [1:0][33:0] imd_val_d_i;
  logic [1:0][33:0] imd_val_q_o;
  logic             ex_valid_i;
  logic [31:0]      result_ex_i;
  logic             wb_valid_o;
  logic             wb_ready_i;
  logic [31:0]      wb_result_o;
  logic             busy_o;
  logic             timeout_o;

  logic [8:0] dutFlags;
  assign dutFlags = {issue_ready_o, alu_instr_first_cycle_o, mult_en_o, div_en_o,
                     mult_sel_o, div_sel_o, wb_valid_o, busy_o, timeout_o};

  cve2_ex_ctrl #(
    .RV32M     (cve2_pkg::RV32MFast),
    .ExTimeout (ExTimeout)
  ) dut (
    .clk_i                   (clk_i),
    .rst_ni                  (rst_ni),
    .issue_valid_i           (issue_valid_i),
    .issue_ready_o           (issue_ready_o),
    .issue_kind_i            (issue_kind_i),
    .kill_i                  (kill_i),
    .alu_instr_first_cycle_o (alu_instr_first_cycle_o),
    .mult_en_o               (mult_en_o),
    .div_en_o                (div_en_o),
    .mult_sel_o              (mult_sel_o),
    .div_sel_o               (div_sel_o),
    .imd_val_we_i            (imd_val_we_i),
    .imd_val_d_i             (imd_val_d_i),
    .imd_val_q_o             (imd_val_q_o),
    .ex_valid_i              (ex_valid_i),
    .result_ex_i             (result_ex_i),
    .wb_valid_o              (wb_valid_o),
    .wb_ready_i              (wb_ready_i),
    .wb_result_o             (wb_result_o),
    .busy_o                  (busy_o),
    .timeout_o               (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        iv;
    logic [1:0]  kind;
    logic        kill;
    logic        exv;
    logic [31:0] res;
    logic        wbr;
    logic [8:0]  expFlags;
    logic [31:0] expRes;
  } vec_t;

  vec_t vecs[$];

  int nChecks = 0;
  int nFail   = 0;

  logic [1:0][33:0] imdA, imdB, imdC;

  // Behavioural model state for the randomized phase (0 idle, 1 executing, 2 result held)
  int               mPhase;
  int               mExecCycle;
  logic [1:0]       mKind;
  logic [31:0]      mHeld;
  logic [1:0][33:0] mImd;
  int               exPct;

  logic             rIv, rKill, rExv, rWbr;
  logic [1:0]       rKind, rWe;
  logic [31:0]      rRes;
  logic [1:0][33:0] rD;
  logic [8:0]       expF;
  logic             eExec;

  function automatic vec_t mkVec(input logic iv, input logic [1:0] kind, input logic kill,
                                 input logic exv, input logic [31:0] res, input logic wbr,
                                 input logic [8:0] expFlags, input logic [31:0] expRes);
    vec_t v;
    v.iv = iv; v.kind = kind; v.kill = kill; v.exv = exv; v.res = res; v.wbr = wbr;
    v.expFlags = expFlags; v.expRes = expRes;
    return v;
  endfunction

  task automatic applyStimulus(input logic iv, input logic [1:0] kind, input logic kill,
                               input logic exv, input logic [31:0] res, input logic wbr,
                               input logic [1:0] we, input logic [1:0][33:0] d);
    issue_valid_i = iv;
    issue_kind_i  = kind;
    kill_i        = kill;
    ex_valid_i    = exv;
    result_ex_i   = res;
    wb_ready_i    = wbr;
    imd_val_we_i  = we;
    imd_val_d_i   = d;
    #2;
  endtask

  task automatic checkOutput(input string name, input logic [67:0] act, input logic [67:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idleIn(input logic [1:0] we, input logic [1:0][33:0] d);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 1'b1, we, d);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global time limit reached");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    imdA = {34'h2_0000_0001, 34'h0_FFFF_FFFF};
    imdB = {34'h1_5555_AAAA, 34'h3_0F0F_F0F0};
    imdC = {34'h0_0000_0000, 34'h1_2345_6789};

    rst_ni = 1'b0;
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00, '0);
    repeat (2) @(posedge clk_i);
    #1;
    #2;
    checkOutput("reset flags", 68'(dutFlags), 68'(9'h000));
    checkOutput("reset imd", imd_val_q_o, 68'h0);
    checkOutput("reset result", 68'(wb_result_o), 68'h0);
    rst_ni = 1'b1;
    #2;
    checkOutput("post-reset ready", 68'(dutFlags), 68'(fRdy));

    // Directed vector table, one row per cycle, starting in IDLE
    vecs.push_back(mkVec(1, 2'd0, 0, 0, 32'h0,         1, fRdy,                  32'h0));
    vecs.push_back(mkVec(0, 2'd0, 0, 1, 32'h0000_1234, 1, fFirst | fBusy,        32'h0));
    vecs.push_back(mkVec(0, 2'd0, 0, 0, 32'h0,         1, fRdy | fValid | fBusy, 32'h0000_1234));
    vecs.push_back(mkVec(0, 2'd0, 0, 0, 32'h0,         1, fRdy,                  32'h0));
    vecs.push_back(mkVec(1, 2'd0, 0, 0, 32'h0,         0, fRdy,                  32'h0));
    vecs.push_back(mkVec(0, 2'd0, 0, 1, 32'hDEAD_BEEF, 0, fFirst | fBusy,        32'h0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mkVec(0, 2'd0, 0, 1, 32'h1111_1111, 0, fValid | fBusy, 32'hDEAD_BEEF));
    vecs.push_back(mkVec(1, 2'd1, 0, 0, 32'h0,         1, fRdy | fValid | fBusy, 32'hDEAD_BEEF));
    vecs.push_back(mkVec(0, 2'd0, 0, 0, 32'h0,         1, fFirst | fMul | fBusy, 32'h0));
    vecs.push_back(mkVec(0, 2'd0, 0, 1, 32'h0000_0055, 1, fMul | fBusy,          32'h0));
    vecs.push_back(mkVec(0, 2'd0, 0, 0, 32'h0,         1, fRdy | fValid | fBusy, 32'h0000_0055));
    vecs.push_back(mkVec(1, 2'd3, 0, 0, 32'h0,         1, fRdy,                  32'h0));
    vecs.push_back(mkVec(0, 2'd0, 0, 1, 32'h0000_A5A5, 1, fFirst | fBusy,        32'h0));
    vecs.push_back(mkVec(0, 2'd0, 0, 0, 32'h0,         0, fValid | fBusy,        32'h0000_A5A5));
    vecs.push_back(mkVec(0, 2'd0, 0, 0, 32'h0,         1, fRdy | fValid | fBusy, 32'h0000_A5A5));
    vecs.push_back(mkVec(1, 2'd0, 1, 0, 32'h0,         1, 9'h000,                32'h0));
    vecs.push_back(mkVec(0, 2'd0, 0, 0, 32'h0,         1, fRdy,                  32'h0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].iv, vecs[i].kind, vecs[i].kill, vecs[i].exv, vecs[i].res,
                    vecs[i].wbr, 2'b00, '0);
      checkOutput($sformatf("vec%0d flags", i), 68'(dutFlags), 68'(vecs[i].expFlags));
      if ((vecs[i].expFlags & fValid) != 9'h000)
        checkOutput($sformatf("vec%0d result", i), 68'(wb_result_o), 68'(vecs[i].expRes));
      cycle();
    end

    // DIV lasting 35 EXEC cycles with an intermediate-register write in the first one
    applyStimulus(1, 2'd2, 0, 0, 32'h0, 0, 2'b00, '0);
    checkOutput("div accept", 68'(dutFlags), 68'(fRdy));
    cycle();
    for (int c = 1; c <= 35; c++) begin
      applyStimulus(0, 2'd0, 0, (c == 35), 32'hCAFE_F00D, 0, (c == 1) ? 2'b11 : 2'b00, imdA);
      checkOutput($sformatf("div exec%0d flags", c), 68'(dutFlags),
                  68'(((c == 1) ? fFirst : 9'h000) | fDiv | fBusy));
      if (c == 2) checkOutput("div imd visible", imd_val_q_o, imdA);
      cycle();
    end
    applyStimulus(0, 2'd0, 0, 0, 32'h0, 0, 2'b11, imdB);
    checkOutput("div wb flags", 68'(dutFlags), 68'(fValid | fBusy));
    checkOutput("div wb result", 68'(wb_result_o), 68'(32'hCAFE_F00D));
    cycle();
    applyStimulus(0, 2'd0, 0, 0, 32'h0, 1, 2'b00, imdB);
    checkOutput("div wb handshake", 68'(dutFlags), 68'(fRdy | fValid | fBusy));
    cycle();
    idleIn(2'b11, imdB);
    checkOutput("div idle", 68'(dutFlags), 68'(fRdy));
    cycle();
    idleIn(2'b00, '0);
    checkOutput("imd write outside exec ignored", imd_val_q_o, imdA);
    cycle();

    // Kill in EXEC cycle 3 of a MULT, same cycle as an imd write and ex_valid
    applyStimulus(1, 2'd1, 0, 0, 32'h0, 1, 2'b00, '0);
    cycle();
    for (int c = 1; c <= 3; c++) begin
      applyStimulus(0, 2'd0, (c == 3), (c == 3), 32'h0000_0099, 1,
                    (c == 3) ? 2'b01 : 2'b00, imdC);
      checkOutput($sformatf("kill exec%0d flags", c), 68'(dutFlags),
                  68'(((c == 1) ? fFirst : 9'h000) | fMul | fBusy));
      cycle();
    end
    idleIn(2'b00, '0);
    checkOutput("kill idle flags", 68'(dutFlags), 68'(fRdy));
    checkOutput("kill imd cleared", imd_val_q_o, 68'h0);
    cycle();
    idleIn(2'b00, '0);
    checkOutput("kill no wb", 68'(dutFlags), 68'(fRdy));
    cycle();

    // Watchdog: ALU op that never completes
    applyStimulus(1, 2'd0, 0, 0, 32'h0, 1, 2'b00, '0);
    cycle();
    for (int c = 1; c <= ExTimeout; c++) begin
      idleIn(2'b00, '0);
      checkOutput($sformatf("wd exec%0d flags", c), 68'(dutFlags),
                  68'(((c == 1) ? fFirst : 9'h000) | fBusy | ((c == ExTimeout) ? fTout : 9'h000)));
      cycle();
    end
    idleIn(2'b00, '0);
    checkOutput("wd idle", 68'(dutFlags), 68'(fRdy));
    cycle();
    idleIn(2'b00, '0);
    checkOutput("wd no wb", 68'(dutFlags), 68'(fRdy));
    cycle();

    // Synchronous reset in EXEC cycle 2 of a DIV
    applyStimulus(1, 2'd2, 0, 0, 32'h0, 1, 2'b00, '0);
    cycle();
    applyStimulus(0, 2'd0, 0, 0, 32'h0, 1, 2'b11, imdB);
    checkOutput("rst exec1 flags", 68'(dutFlags), 68'(fFirst | fDiv | fBusy));
    cycle();
    idleIn(2'b00, '0);
    checkOutput("rst imd before", imd_val_q_o, imdB);
    rst_ni = 1'b0;
    cycle();
    idleIn(2'b00, '0);
    checkOutput("rst mid-op flags", 68'(dutFlags), 68'(9'h000));
    checkOutput("rst mid-op imd", imd_val_q_o, 68'h0);
    checkOutput("rst mid-op result", 68'(wb_result_o), 68'h0);
    rst_ni = 1'b1;
    #1;
    checkOutput("rst release ready", 68'(dutFlags), 68'(fRdy));
    cycle();
    idleIn(2'b00, '0);
    checkOutput("rst no wb/timeout", 68'(dutFlags), 68'(fRdy));
    cycle();

    // Reset glitch between edges must not disturb a running op
    applyStimulus(1, 2'd0, 0, 0, 32'h0, 1, 2'b00, '0);
    cycle();
    idleIn(2'b00, '0);
    checkOutput("glitch exec1", 68'(dutFlags), 68'(fFirst | fBusy));
    rst_ni = 1'b0;
    #2;
    rst_ni = 1'b1;
    cycle();
    applyStimulus(0, 2'd0, 0, 1, 32'h0000_0077, 1, 2'b00, '0);
    checkOutput("glitch exec2", 68'(dutFlags), 68'(fBusy));
    cycle();
    idleIn(2'b00, '0);
    checkOutput("glitch wb flags", 68'(dutFlags), 68'(fRdy | fValid | fBusy));
    checkOutput("glitch wb result", 68'(wb_result_o), 68'(32'h0000_0077));
    cycle();

    // Randomized phase against the behavioural model
    rst_ni = 1'b0;
    idleIn(2'b00, '0);
    cycle();
    cycle();
    rst_ni = 1'b1;
    mPhase = 0; mExecCycle = 0; mKind = 2'b00; mHeld = '0; mImd = '0; exPct = 30;
    for (int n = 0; n < 600; n++) begin
      rIv   = 1'($urandom_range(1));
      rKind = 2'($urandom_range(3));
      rKill = ($urandom_range(49) == 0);
      rExv  = ($urandom_range(99) < exPct);
      rRes  = $urandom;
      rWbr  = ($urandom_range(2) != 0);
      rWe   = ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'b00;
      rD    = {2'($urandom_range(3)), $urandom, 2'($urandom_range(3)), $urandom};
      applyStimulus(rIv, rKind, rKill, rExv, rRes, rWbr, rWe, rD);

      eExec = (mPhase == 1);
      expF  = 9'h000;
      if ((mPhase == 0 && !rKill) || (mPhase == 2 && rWbr && !rKill)) expF |= fRdy;
      if (eExec && mExecCycle == 1) expF |= fFirst;
      if (eExec && mKind == 2'd1) expF |= fMul;
      if (eExec && mKind == 2'd2) expF |= fDiv;
      if (mPhase == 2) expF |= fValid;
      if (mPhase != 0) expF |= fBusy;
      if (eExec && !rKill && !rExv && mExecCycle == ExTimeout) expF |= fTout;
      checkOutput($sformatf("rnd%0d flags", n), 68'(dutFlags), 68'(expF));
      checkOutput($sformatf("rnd%0d imd", n), imd_val_q_o, mImd);
      if (mPhase == 2) checkOutput($sformatf("rnd%0d result", n), 68'(wb_result_o), 68'(mHeld));
      cycle();

      case (mPhase)
        0: if (rIv && !rKill) begin
             mPhase = 1; mKind = rKind; mExecCycle = 1;
             exPct = ($urandom_range(9) == 0) ? 0 : 30;
           end
        1: if (rKill) begin
             mPhase = 0; mImd = '0;
           end else begin
             for (int k = 0; k < 2; k++) if (rWe[k]) mImd[k] = rD[k];
             if (rExv) begin
               mPhase = 2; mHeld = rRes;
             end else if (mExecCycle == ExTimeout) begin
               mPhase = 0;
             end else begin
               mExecCycle++;
             end
           end
        default: if (rKill) begin
             mPhase = 0; mImd = '0;
           end else if (rWbr) begin
             if (rIv) begin
               mPhase = 1; mKind = rKind; mExecCycle = 1;
               exPct = ($urandom_range(9) == 0) ? 0 : 30;
             end else begin
               mPhase = 0;
             end
           end
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
